// File: rtl/filter_step_ctrl.sv
// rtl/filter_step_ctrl.sv - sample-rate step sequencer for an IIR datapath with warm-up, saturation and flush
module filter_step_ctrl #(
    parameter int DIV     = 1024,
    parameter int WARMUP  = 64,
    parameter int CLR_CYC = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [31:0] in_data,
    output logic        in_ready,
    output logic [31:0] filt_x,
    output logic        filt_step,
    output logic        filt_clr,
    input  logic [31:0] filt_y,
    output logic        out_valid,
    output logic [23:0] out_data,
    input  logic        out_ready,
    input  logic        flush,
    output logic [3:0]  status
);

    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int CCW = (CLR_CYC > 1) ? $clog2(CLR_CYC) : 1;
    localparam int WW  = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;

    localparam logic [0:0] S_RUN   = 1'b0;
    localparam logic [0:0] S_FLUSH = 1'b1;

    logic [0:0]     state;
    logic [CW-1:0]  tick_cnt;
    logic [CCW-1:0] clr_cnt;
    logic [WW-1:0]  warm_cnt;
    logic           buf_full;
    logic [31:0]    buf_data;
    logic           sat_flag;
    logic           ovr_flag;
    logic           und_flag;

    logic           run;
    logic           tick;
    logic           accept;
    logic           capture;
    logic           sat_hit;
    logic [23:0]    sat_word;

    assign run       = (state == S_RUN);
    assign tick      = run && (tick_cnt == CW'(DIV - 1));
    assign in_ready  = run && (!buf_full || tick);
    assign accept    = in_valid && in_ready;
    assign filt_step = tick;
    assign filt_clr  = !run;
    assign filt_x    = (tick && buf_full) ? buf_data : 32'd0;
    // Steps taken while warm-up remains are discarded.
    assign capture   = tick && (warm_cnt == '0);
    assign status    = {sat_flag, ovr_flag, und_flag, run && (warm_cnt == '0)};

    always_comb begin
        sat_hit  = 1'b0;
        sat_word = filt_y[23:0];
        if ($signed(filt_y) > 32'sd8388607) begin
            sat_hit  = 1'b1;
            sat_word = 24'h7fffff;
        end else if ($signed(filt_y) < -32'sd8388608) begin
            sat_hit  = 1'b1;
            sat_word = 24'h800000;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_FLUSH;
            clr_cnt   <= '0;
            tick_cnt  <= '0;
            warm_cnt  <= WW'(WARMUP);
            buf_full  <= 1'b0;
            buf_data  <= 32'd0;
            out_valid <= 1'b0;
            out_data  <= 24'd0;
            sat_flag  <= 1'b0;
            ovr_flag  <= 1'b0;
            und_flag  <= 1'b0;
        end else begin
            if (tick && !buf_full)
                und_flag <= 1'b1;
            if (capture && sat_hit)
                sat_flag <= 1'b1;
            if (capture && out_valid && !out_ready)
                ovr_flag <= 1'b1;

            if (flush) begin
                // Anything pending in this cycle is abandoned; flags stay sticky.
                state     <= S_FLUSH;
                clr_cnt   <= '0;
                tick_cnt  <= '0;
                warm_cnt  <= WW'(WARMUP);
                buf_full  <= 1'b0;
                out_valid <= 1'b0;
            end else begin
                if (state == S_FLUSH) begin
                    if (clr_cnt == CCW'(CLR_CYC - 1)) begin
                        state   <= S_RUN;
                        clr_cnt <= '0;
                    end else begin
                        clr_cnt <= clr_cnt + 1'b1;
                    end
                end else begin
                    tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
                end

                if (accept) begin
                    buf_full <= 1'b1;
                    buf_data <= in_data;
                end else if (tick) begin
                    buf_full <= 1'b0;
                end

                if (tick && (warm_cnt != '0))
                    warm_cnt <= warm_cnt - 1'b1;

                if (capture) begin
                    out_valid <= 1'b1;
                    out_data  <= sat_word;
                end else if (out_ready) begin
                    out_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_filter_step_ctrl.sv
// tb/tb_filter_step_ctrl.sv - scoreboard bench for filter_step_ctrl with a behavioural sample-period model
module tb_filter_step_ctrl;

    localparam int DIV     = 8;
    localparam int WARMUP  = 3;
    localparam int CLR_CYC = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = 32'd0;
    logic        in_ready;
    logic [31:0] filt_x;
    logic        filt_step;
    logic        filt_clr;
    logic [31:0] filt_y;
    logic        out_valid;
    logic [23:0] out_data;
    logic        out_ready = 1'b0;
    logic        flush = 1'b0;
    logic [3:0]  status;

    filter_step_ctrl #(.DIV(DIV), .WARMUP(WARMUP), .CLR_CYC(CLR_CYC)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .filt_x(filt_x), .filt_step(filt_step),
        .filt_clr(filt_clr), .filt_y(filt_y), .out_valid(out_valid),
        .out_data(out_data), .out_ready(out_ready), .flush(flush), .status(status)
    );

    // Identity datapath: the filter output equals the presented sample.
    assign filt_y = filt_x;

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [31:0] step_q[$];
    logic [23:0] out_q[$];

    int          clr_left;
    int          run_cyc;
    int          warm_left;
    bit          pend;
    logic [31:0] pend_val;
    bit          out_pend;
    bit          f_sat, f_ovr, f_und;
    bit          drop_q;
    bit          acc_m;
    bit          mon_en = 1'b0;
    bit          first_cyc = 1'b0;
    bit          prev_rs = 1'b1;
    bit          e_clr, e_rdy, e_step, e_ov;
    logic [3:0]  e_status;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [24:0] sat24(input logic [31:0] v);
        int s;
        s = int'(v);
        if (s > 8388607)
            return {1'b1, 24'h7fffff};
        if (s < -8388608)
            return {1'b1, 24'h800000};
        return {1'b0, v[23:0]};
    endfunction

    task automatic model_reset();
        clr_left  = CLR_CYC;
        run_cyc   = 0;
        warm_left = WARMUP;
        pend      = 1'b0;
        out_pend  = 1'b0;
        f_sat     = 1'b0;
        f_ovr     = 1'b0;
        f_und     = 1'b0;
        drop_q    = 1'b0;
        acc_m     = 1'b0;
        step_q.delete();
        out_q.delete();
    endtask

    // One sample-period-level step of the reference: a tick ends every DIV-th RUN cycle.
    task automatic model_step(input bit iv, input logic [31:0] id, input bit ordy, input bit fl);
        bit          run, tick, cap;
        logic [31:0] x;
        logic [24:0] y;
        run      = (clr_left == 0);
        tick     = run && (run_cyc % DIV == DIV - 1);
        cap      = 1'b0;
        e_clr    = !run;
        e_rdy    = run && (!pend || tick);
        e_step   = tick;
        e_ov     = out_pend;
        e_status = {f_sat, f_ovr, f_und, run && (warm_left == 0)};
        acc_m    = iv && e_rdy;
        if (tick) begin
            x = pend ? pend_val : 32'd0;
            if (!pend) f_und = 1'b1;
            step_q.push_back(x);
            if (warm_left > 0) begin
                warm_left--;
            end else begin
                y = sat24(x);
                if (y[24]) f_sat = 1'b1;
                if (out_pend && !ordy) begin
                    f_ovr = 1'b1;
                    void'(out_q.pop_back());
                end
                out_q.push_back(y[23:0]);
                cap = 1'b1;
            end
        end
        if (acc_m) begin
            pend     = 1'b1;
            pend_val = id;
        end else if (tick) begin
            pend = 1'b0;
        end
        if (cap) out_pend = 1'b1;
        else if (ordy) out_pend = 1'b0;
        if (run) run_cyc++;
        else clr_left--;
        if (fl) begin
            clr_left  = CLR_CYC;
            run_cyc   = 0;
            pend      = 1'b0;
            out_pend  = 1'b0;
            warm_left = WARMUP;
            drop_q    = 1'b1;
        end
    endtask

    task automatic cyc(input bit rs, input bit iv, input logic [31:0] id, input bit ordy, input bit fl);
        @(posedge clk);
        #1;
        reset     = rs;
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        flush     = fl;
        if (drop_q) begin
            out_q.delete();
            drop_q = 1'b0;
        end
        first_cyc = !rs && prev_rs;
        prev_rs   = rs;
        if (rs) begin
            mon_en = 1'b0;
            model_reset();
        end else begin
            mon_en = 1'b1;
            model_step(iv, id, ordy, fl);
        end
    endtask

    task automatic send(input logic [31:0] d, input bit ordy);
        for (int i = 0; i < 3 * DIV; i++) begin
            cyc(1'b0, 1'b1, d, ordy, 1'b0);
            if (acc_m) return;
        end
        checks++;
        errors++;
        $display("FAIL send_timeout actual=not_accepted required=accepted within %0d cycles", 3 * DIV);
    endtask

    function automatic logic [31:0] rnd_data();
        logic [31:0] r;
        r = $urandom;
        case ($urandom % 3)
            0: return r;
            1: return {{8{r[23]}}, r[23:0]};
            default: return 32'(int'($urandom_range(0, 20000)) - 10000);
        endcase
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            chk("filt_clr", 64'(filt_clr), 64'(e_clr));
            chk("in_ready", 64'(in_ready), 64'(e_rdy));
            chk("filt_step", 64'(filt_step), 64'(e_step));
            chk("out_valid", 64'(out_valid), 64'(e_ov));
            chk("status", 64'(status), 64'(e_status));
            if (first_cyc)
                chk("out_data_after_reset", 64'(out_data), 64'd0);
            if (filt_step) begin
                if (step_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_step actual=step required=no step");
                end else begin
                    chk("filt_x", 64'(filt_x), 64'(step_q.pop_front()));
                end
            end else begin
                chk("filt_x_idle", 64'(filt_x), 64'd0);
            end
            if (out_valid && out_ready) begin
                if (out_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output actual=%0h required=none", out_data);
                end else begin
                    chk("out_data", 64'(out_data), 64'(out_q.pop_front()));
                end
            end
        end
    end

    initial begin
        model_reset();
        repeat (3) cyc(1'b1, 1'b1, 32'hdead_beef, 1'b1, 1'b1);

        // Idle after reset: clear window, tick cadence, underrun steps eat the warm-up.
        repeat (4 * DIV) cyc(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);

        // Fresh reset, five samples one per period.
        repeat (2) cyc(1'b1, 1'b0, 32'd0, 1'b1, 1'b0);
        for (int k = 0; k < 5; k++) send(rnd_data(), 1'b1);
        repeat (2 * DIV) cyc(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);

        // Saturation at both rails.
        send(32'd9000000, 1'b1);
        send(-32'sd9000000, 1'b1);
        repeat (3 * DIV) cyc(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);

        // Back-to-back input with a stalled sink: full-buffer accepts at ticks and overruns.
        repeat (4 * DIV) cyc(1'b0, 1'b1, rnd_data(), 1'b0, 1'b0);
        repeat (2) cyc(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);

        // Flush with a buffered sample and an unread output, then flush inside FLUSH.
        repeat (2 * DIV) cyc(1'b0, 1'b1, rnd_data(), 1'b0, 1'b0);
        cyc(1'b0, 1'b1, rnd_data(), 1'b0, 1'b1);
        cyc(1'b0, 1'b1, rnd_data(), 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
        repeat (5 * DIV) cyc(1'b0, 1'($urandom % 2), rnd_data(), 1'b1, 1'b0);

        // Random traffic with occasional flush and reset.
        repeat (800) begin
            cyc(1'($urandom % 400 == 0), 1'($urandom % 2), rnd_data(),
                1'($urandom % 4 != 0), 1'($urandom % 90 == 0));
        end

        repeat (4 * DIV) cyc(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
        @(negedge clk);
        #1;
        chk("steps_outstanding", 64'(step_q.size()), 64'd0);
        chk("outputs_outstanding", 64'(out_q.size()), 64'(out_pend));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/filter_step_ctrl.md
FILTER_STEP_CTRL -- requirements
Module: filter_step_ctrl

Interface
REQ-001 SHALL have parameter DIV, default 1024, meaning clk cycles per audio sample period (DIV >= 4).
REQ-002 SHALL have parameter WARMUP, default 64, meaning filter steps discarded after reset/flush (0 allowed).
REQ-003 SHALL have parameter CLR_CYC, default 2, meaning cycles filt_clr is held during flush (>= 1).
REQ-004 clk  input  1  system clock; all logic on rising edge.
REQ-005 reset  input  1  reset, synchronous, active-high.
REQ-006 in_valid  input  1  upstream sample valid.
REQ-007 in_data  input  32  signed upstream sample.
REQ-008 in_ready  output  1  controller can accept a sample this cycle.
REQ-009 filt_x  output  32  signed sample presented to the IIR datapath.
REQ-010 filt_step  output  1  one-cycle step enable to the IIR datapath.
REQ-011 filt_clr  output  1  clear of the IIR datapath history registers.
REQ-012 filt_y  input  32  signed combinational datapath output for current filt_x.
REQ-013 out_valid  output  1  output word valid.
REQ-014 out_data  output  24  signed saturated codec word.
REQ-015 out_ready  input  1  downstream accepts out_data.
REQ-016 flush  input  1  single-cycle request to clear filter and restart warm-up.
REQ-017 status  output  4  sticky flags {sat, overrun, underrun, warm}; warm = warm-up complete (non-sticky level).

Function
REQ-018 Tick counter SHALL count 0..DIV-1 and wrap; tick is asserted in the cycle count == DIV-1.
REQ-019 Input buffer SHALL be one entry; in_ready = !buf_full || tick, in state RUN only; 0 in FLUSH.
REQ-020 Accept (in_valid && in_ready) SHALL load buffer; accept in a tick cycle when full SHALL load new sample after the old one is consumed (no loss).
REQ-021 States SHALL be RUN and FLUSH; reset and flush both enter FLUSH.
REQ-022 FLUSH: filt_clr = 1 for exactly CLR_CYC cycles, tick counter held at 0, input/output buffers emptied, warm-up counter loaded with WARMUP, then RUN.
REQ-023 RUN, tick cycle: filt_step = 1 for that cycle only; filt_x = buffered sample if full, else 0 with underrun set.
REQ-024 filt_x SHALL be 0 in every non-tick cycle; filt_step SHALL never assert in FLUSH.
REQ-025 filt_y SHALL be sampled in the filt_step cycle (before datapath history update); out_valid rises the following cycle (latency 1).
REQ-026 Warm-up: while warm-up counter > 0, each step decrements it and its output is discarded (no out_valid); warm = (counter == 0).
REQ-027 Saturation: filt_y > 8388607 -> 8388607, < -8388608 -> -8388608, sat set; otherwise low 24 bits passed unchanged.
REQ-028 Output buffer one entry; cleared on out_valid && out_ready; new capture while still valid SHALL overwrite and set overrun.
REQ-029 Capture and out_ready in the same cycle SHALL leave out_valid = 1 with the new word, no overrun.
REQ-030 flush during RUN SHALL take effect next cycle, abandoning pending sample and output; flush during FLUSH restarts CLR_CYC count.
REQ-031 Sticky flags SHALL clear only on reset (not on flush).
REQ-032 out_data SHALL hold stable while out_valid && !out_ready.

Reset
REQ-033 reset SHALL force FLUSH; first post-reset cycle: filt_clr=1, filt_step=0, filt_x=0, in_ready=0, out_valid=0, out_data=0, status=0000 (warm=1 only when WARMUP=0, after FLUSH).
REQ-034 reset SHALL dominate flush and all handshakes in the same cycle; reset mid-step discards the capture.

Verification
REQ-035 Reset release, DIV=8, CLR_CYC=2 -> filt_clr high cycles 0-1, first filt_step 8 cycles after RUN entry, then every 8 cycles.
REQ-036 WARMUP=3, feed 5 samples one per period -> filt_step 5 times, out_valid exactly twice (steps 4 and 5), warm rises after step 3.
REQ-037 filt_y = 9000000 then -9000000 -> out_data 8388607 then -8388608, sat sticky = 1.
REQ-038 No input at a tick -> filt_x = 0 during filt_step, underrun = 1; sample arriving in tick cycle with buffer full -> both samples used on consecutive ticks.
REQ-039 out_ready held 0 across two captures -> overrun = 1, out_data = second word; capture with out_ready=1 same cycle -> no overrun.
REQ-040 flush with buffered sample and pending output -> out_valid=0, in_ready=0 for CLR_CYC cycles, warm-up reloaded, flags retained.
